// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Combinational helpers only; no state lives here.
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int unsigned MAX_HOLD_DEF = 8;
    localparam logic [1:0]  PTR_RST      = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant).
interface rr_arbiter4_if;
    import rr_arbiter4_pkg::*;

    logic       req0;
    logic       req1;
    logic       req2;
    logic       req3;
    logic       gnt0;
    logic       gnt1;
    logic       gnt2;
    logic       gnt3;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    modport master (
        output req0, req1, req2, req3,
        input  gnt0, gnt1, gnt2, gnt3, gnt_idx, gnt_valid
    );

    modport slave (
        input  req0, req1, req2, req3,
        output gnt0, gnt1, gnt2, gnt3, gnt_idx, gnt_valid
    );

endinterface

// File: rtl/rr_arbiter4_pick4.sv
// Rotated 4-to-2 priority encoder: first unmasked request in ptr+1..ptr+4 order.
// Purely combinational; idx is 00 whenever found is low.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [3:0] mask_i,
    input  logic [1:0] ptr_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    logic [3:0] elig;

    assign elig = req_i & ~mask_i;

    // Walk from lowest to highest priority so the nearest-after-ptr hit is the one left standing.
    always_comb begin
        found_o = 1'b0;
        idx_o   = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            if (elig[ptr_i + 2'(k)]) begin
                found_o = 1'b1;
                idx_o   = ptr_i + 2'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and bounded hold.
// Grant/handoff visible one cycle after the deciding edge; requesters hold req until served.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter4_if.slave    bus
);

    localparam int unsigned   CW      = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic [3:0]    req_vec;
    logic [3:0]    pick_mask;
    logic [1:0]    pick_ptr;
    logic          pick_found;
    logic [1:0]    pick_idx;

    assign req_vec = {bus.req3, bus.req2, bus.req1, bus.req0};

    // While granted, the owner is about to become "last", so the search rotates from it.
    always_comb begin
        pick_mask = 4'b0000;
        pick_ptr  = last_q;
        if (state_q == ST_GRANT) begin
            pick_mask = onehot4(owner_q);
            pick_ptr  = owner_q;
        end
    end

    rr_pick4 u_pick (
        .req_i   (req_vec),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!req_vec[owner_q]) begin
                    last_d     = owner_q;
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hold_cnt_q == CNT_MAX && pick_found) begin
                    last_d     = owner_q;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 2'b00;
            last_q     <= PTR_RST;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    logic granted;
    assign granted = (state_q == ST_GRANT);

    assign bus.gnt0      = granted && (owner_q == 2'd0);
    assign bus.gnt1      = granted && (owner_q == 2'd1);
    assign bus.gnt2      = granted && (owner_q == 2'd2);
    assign bus.gnt3      = granted && (owner_q == 2'd3);
    assign bus.gnt_idx   = granted ? owner_q : 2'b00;
    assign bus.gnt_valid = granted;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with a per-cycle reference model of round-robin ownership.
module tb_rr_arbiter4;

    localparam int MAXH = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gv();
        return {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
    endfunction

    task automatic set_req(input logic [3:0] r);
        bus.req0 = r[0];
        bus.req1 = r[1];
        bus.req2 = r[2];
        bus.req3 = r[3];
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: owner (-1 = none), pointer, and how many cycles the owner has held.
    int m_owner  = -1;
    int m_last   = 3;
    int m_tenure = 0;
    bit m_live   = 1'b0;

    function automatic int rr_next(input logic [3:0] r, input int from, input int excl);
        for (int d = 1; d <= 4; d++) begin
            int c;
            c = (from + d) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        logic [3:0] r;
        int c;
        r = {bus.req3, bus.req2, bus.req1, bus.req0};
        if (rst) begin
            m_owner  = -1;
            m_last   = 3;
            m_tenure = 0;
            m_live   = 1'b1;
        end else if (m_owner < 0) begin
            c = rr_next(r, m_last, -1);
            if (c >= 0) begin
                m_owner  = c;
                m_tenure = 1;
            end
        end else if (!r[m_owner]) begin
            c        = rr_next(r, m_owner, m_owner);
            m_last   = m_owner;
            m_owner  = c;
            m_tenure = (c >= 0) ? 1 : 0;
        end else if (m_tenure >= MAXH && rr_next(r, m_owner, m_owner) >= 0) begin
            c        = rr_next(r, m_owner, m_owner);
            m_last   = m_owner;
            m_owner  = c;
            m_tenure = 1;
        end else begin
            m_tenure++;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_gnt", int'(gv()), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("model_idx", int'(bus.gnt_idx), (m_owner >= 0) ? m_owner : 0);
            check("model_valid", int'(bus.gnt_valid), (m_owner >= 0) ? 1 : 0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        set_req(4'b0000);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        set_req(4'b0000);
        step();
        step();
        check("rst_gnt", int'(gv()), 0);
        check("rst_idx", int'(bus.gnt_idx), 0);
        check("rst_valid", int'(bus.gnt_valid), 0);
        rst = 1'b0;

        // Single requester grant and release.
        set_req(4'b0100);
        step();
        check("t1_gnt", int'(gv()), 4'b0100);
        check("t1_idx", int'(bus.gnt_idx), 2);
        check("t1_valid", int'(bus.gnt_valid), 1);
        set_req(4'b0000);
        step();
        check("t1_rel_gnt", int'(gv()), 0);
        check("t1_rel_valid", int'(bus.gnt_valid), 0);

        // All four request; each owner drops after 3 cycles and re-raises after handoff.
        do_reset();
        r = 4'b1111;
        set_req(r);
        step();
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("t2_own%0d_c%0d", i, c), int'(gv()), 1 << order[i]);
                if (c == 0 && i > 0) begin
                    r[order[i-1]] = 1'b1;
                    set_req(r);
                end
                if (c < 2) step();
            end
            r[order[i]] = 1'b0;
            set_req(r);
            step();
        end
        check("t2_after", int'(bus.gnt_idx), 1);

        // Preemption after exactly MAXH cycles, then handback on release.
        do_reset();
        set_req(4'b0010);
        step();
        set_req(4'b1010);
        for (int c = 1; c <= MAXH; c++) begin
            check($sformatf("t3_hold%0d", c), int'(gv()), 4'b0010);
            step();
        end
        check("t3_preempt", int'(gv()), 4'b1000);
        check("t3_pre_idx", int'(bus.gnt_idx), 3);
        set_req(4'b0010);
        step();
        check("t3_back", int'(gv()), 4'b0010);

        // Uncontested owner keeps grant; counter saturates.
        do_reset();
        set_req(4'b0001);
        step();
        for (int c = 0; c < 20; c++) begin
            check("t4_hold", int'(gv()), 4'b0001);
            step();
        end
        check("t4_cnt_sat", int'(dut.hold_cnt_q), MAXH - 1);

        // Reset mid-grant; requests ignored during reset; req0 first afterwards.
        do_reset();
        set_req(4'b0100);
        step();
        check("t5_gnt2", int'(gv()), 4'b0100);
        step();
        rst = 1'b1;
        set_req(4'b1111);
        step();
        check("t5_rst_gnt", int'(gv()), 0);
        check("t5_rst_valid", int'(bus.gnt_valid), 0);
        step();
        check("t5_rst_hold", int'(gv()), 0);
        rst = 1'b0;
        step();
        check("t5_first", int'(gv()), 4'b0001);

        // Same-cycle release/raise, and rotation order from the owner.
        do_reset();
        set_req(4'b0010);
        step();
        set_req(4'b0001);
        step();
        check("t6_to0", int'(gv()), 4'b0001);
        do_reset();
        set_req(4'b0010);
        step();
        set_req(4'b0101);
        step();
        check("t6_to2", int'(gv()), 4'b0100);
        check("t6_idx", int'(bus.gnt_idx), 2);

        set_req(4'b0000);
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter with a registered one-hot grant and a 2-bit encoded grant index. It shares one downstream resource, such as a bus or output port, among four scalar request lines. It sits in front of that resource and sequences ownership using a bounded hold time. A combinational round-robin priority encoder chooses the next owner; the surrounding FSM registers and holds the grant.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles an owner keeps the grant while another request is pending. Legal range is 2..256.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous and active-high.
- req0, req1, req2, req3  input  1 each  request lines, level-sensitive. A requester holds its line high for as long as it wants ownership.
- gnt0, gnt1, gnt2, gnt3  output  1 each  registered one-hot grant. At most one is high.
- gnt_idx  output  2  encoded owner index. Forced to 2'b00 whenever gnt_valid=0.
- gnt_valid  output  1  high exactly when one gntN is high.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- Internal registers:
  - last[1:0]: previous owner, used as the round-robin pointer.
  - hold_cnt: width $clog2(MAX_HOLD). Counts cycles in the current grant, minus 1.
- Pick rule: search order is last+1, last+2, last+3, last (mod 4). The first asserted, unmasked request wins.
- IDLE:
  - Any req high → GRANT, with owner = pick(all reqs), hold_cnt=0.
  - No req → stay in IDLE.
- GRANT, owner req low (release):
  - If pick(reqs with owner masked) finds a request → GRANT that index directly, with no idle bubble.
  - Otherwise → IDLE.
  - In both cases last ← old owner and hold_cnt ← 0.
- GRANT, owner req high, hold_cnt==MAX_HOLD-1, and another req pending (preempt):
  - Move to pick(reqs with owner masked); last ← old owner; hold_cnt ← 0.
- GRANT, owner req high otherwise: hold the grant.
  - hold_cnt increments and saturates at MAX_HOLD-1.
  - With no competitor, the owner keeps the grant indefinitely.
- Simultaneous events:
  - Owner release and preemption in the same cycle are treated as a release. The result is identical apart from the masking source.
  - A request rising in the same cycle as the owner's release is eligible for that pick.
- Outputs are derived only from registered state: gntN = (state==GRANT && owner==N).

## Timing
- Reset values: state=IDLE, gnt0..3=0, gnt_idx=2'b00, gnt_valid=0, last=2'b11 (so req0 has top priority first), hold_cnt=0.
- Reset mid-grant: the first edge with rst=1 forces the reset values. Request inputs are ignored while rst=1.
- Grant latency: a req sampled high at edge t in IDLE drives gnt high after edge t (visible in cycle t+1).
- Release latency: an owner req sampled low at edge t drops gnt after edge t. The next owner's gnt rises at that same edge.
- Preemption: a contested owner sees gnt high for exactly MAX_HOLD cycles.
- There is no combinational path from req to any output.

## Structure
- Shared header/package holds:
  - state encodings: IDLE=1'b0, GRANT=1'b1;
  - the MAX_HOLD default;
  - the reset pointer constant 2'b11.
- Sub-module rr_pick4 (combinational):
  - Inputs: req[3:0], mask[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - It is a rotated 4-to-2 priority encoder with a found flag, so idx=00 when found=0.
  - It is instantiated once in rr_arbiter4.
- Top level contains the FSM, the last/hold_cnt registers, and the one-hot decode.

## Test plan
1. After reset, raise req2 only → at the next edge gnt2=1, gnt_idx=2'b10, gnt_valid=1. Drop req2 → after the next edge all grants are 0 and gnt_valid=0.
2. Raise req0–req3 together from reset → grant order 0,1,2,3,0. Each owner drops its req after 3 cycles of grant, and handoff has no idle cycle.
3. MAX_HOLD=8: req1 held high continuously while req3 rises → gnt1 is high for exactly 8 cycles, then gnt3. When req3 then drops → gnt1 returns after a 1-cycle latency.
4. req0 held alone for 20 cycles → gnt0 stays high throughout, hold_cnt saturates at 7, and there is no glitch.
5. rst asserted mid-grant with gnt2=1 → after the next edge all outputs are 0. With all reqs high after reset is released, req0 is granted first.
6. Owner req1 drops in the same cycle req0 rises (last=1) → next owner is 0. With req2 also high, next owner is 2, following the rotation order.
